// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts an 11-bit frame
// on device clock falls and checks the device acknowledge. Drives open-drain enables only.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned RTS_CYCLES     = 20,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] Dato_tx,
   input  logic       iniciar,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       ocupado,
   output logic       listo,
   output logic       error_tx
);
   localparam int unsigned MAX_AB = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int unsigned MAX_P  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int          CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, ACKOK, WAITIDLE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] tmo, tmo_nx;
   logic [3:0]       bit_idx, bit_nx;
   logic [10:0]      frame;
   logic             load;
   logic             tmo_hit;

   logic             c_p0, c_p1, d_p0, d_p1;
   logic [7:0]       filt_sh;
   logic             c_filt;
   logic             fall;
   logic             line_idle;

   // Fall fires in the cycle the filter is about to flip from 1 to 0.
   assign fall      = c_filt & (filt_sh == 8'h00);
   assign line_idle = c_filt & d_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         tmo     <= '0;
         bit_idx <= '0;
         c_p0    <= 1'b1;
         c_p1    <= 1'b1;
         d_p0    <= 1'b1;
         d_p1    <= 1'b1;
         filt_sh <= 8'hFF;
         c_filt  <= 1'b1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         tmo     <= tmo_nx;
         bit_idx <= bit_nx;
         c_p0    <= ps2c_in;
         c_p1    <= c_p0;
         d_p0    <= ps2d_in;
         d_p1    <= d_p0;
         filt_sh <= {filt_sh[6:0], c_p1};
         if (filt_sh == 8'hFF)
            c_filt <= 1'b1;
         else if (filt_sh == 8'h00)
            c_filt <= 1'b0;
      end
   end

   // Frame is pure data: no reset, only loaded on an accepted request.
   always_ff @(posedge clk) begin
      if (load)
         frame <= {1'b1, ~^Dato_tx, Dato_tx, 1'b0};
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tmo_nx   = tmo;
      bit_nx   = bit_idx;
      load     = 1'b0;
      ps2c_oe  = 1'b0;
      ps2d_oe  = 1'b0;
      listo    = 1'b0;
      error_tx = 1'b0;
      ocupado  = (state != IDLE);
      tmo_hit  = (tmo == TMO_LAST);
      case (state)
         IDLE: begin
            if (iniciar) begin
               load     = 1'b1;
               cnt_nx   = '0;
               state_nx = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2c_oe = 1'b1;
            if (cnt == INH_LAST) begin
               cnt_nx   = '0;
               state_nx = RTS;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RTS: begin
            ps2c_oe = 1'b1;
            ps2d_oe = 1'b1;
            if (cnt == RTS_LAST) begin
               cnt_nx   = '0;
               tmo_nx   = '0;
               bit_nx   = '0;
               state_nx = DATA;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DATA: begin
            tmo_nx = tmo + 1'b1;
            if (tmo_hit) begin
               error_tx = 1'b1;
               state_nx = IDLE;
            end else begin
               ps2d_oe = ~frame[bit_idx];
               if (fall) begin
                  bit_nx = bit_idx + 4'd1;
                  if (bit_idx == 4'd9)
                     state_nx = ACK;
               end
            end
         end
         ACK: begin
            tmo_nx = tmo + 1'b1;
            if (tmo_hit) begin
               error_tx = 1'b1;
               state_nx = IDLE;
            end else if (fall) begin
               if (d_p1) begin
                  error_tx = 1'b1;
                  state_nx = WAITIDLE;
               end else begin
                  state_nx = ACKOK;
               end
            end
         end
         ACKOK: begin
            tmo_nx = tmo + 1'b1;
            if (tmo_hit) begin
               error_tx = 1'b1;
               state_nx = IDLE;
            end else if (line_idle) begin
               listo    = 1'b1;
               state_nx = IDLE;
            end
         end
         WAITIDLE: begin
            if (line_idle)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host,
// captures the wire bits on rising edges and answers with ACK or NACK.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INH  = 100;
   localparam int RTSC = 20;
   localparam int TMO  = 3000;
   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iniciar = 1'b0;
   logic [7:0] dato = 8'h00;
   logic       dev_c = 1'b1;
   logic       dev_d = 1'b1;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_oe, ps2d_oe, ocupado, listo, error_tx;

   int tests = 0;
   int fails = 0;
   int n_listo = 0;
   int n_err = 0;
   int n_both = 0;

   assign ps2c_in = dev_c & ~ps2c_oe;
   assign ps2d_in = dev_d & ~ps2d_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .Dato_tx(dato), .iniciar(iniciar),
      .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
      .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .ocupado(ocupado),
      .listo(listo), .error_tx(error_tx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (listo) n_listo++;
      if (error_tx) n_err++;
      if (listo && error_tx) n_both++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_tx(input logic [7:0] b);
      dato = b;
      iniciar = 1'b1;
      cyc(1);
      iniciar = 1'b0;
   endtask

   task automatic wait_release(output int inh, output int rts);
      inh = 0;
      rts = 0;
      while (ps2c_oe && !ps2d_oe && inh < 20000) begin inh++; cyc(1); end
      while (ps2c_oe && ps2d_oe && rts < 20000) begin rts++; cyc(1); end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (ocupado && n < 5000) begin n++; cyc(1); end
   endtask

   // Device model: falls/rises with HALF-cycle phases, samples data on each rise.
   task automatic dev_frame(input bit ack, input int nfalls, input int glitch_k,
                            input int poke_k, output logic [10:0] bits);
      bits = '0;
      bits[0] = ps2d_in;
      cyc(20);
      for (int k = 1; k <= nfalls; k++) begin
         dev_c = 1'b0;
         if (k == poke_k) begin
            dato = 8'hFF; iniciar = 1'b1; cyc(1); iniciar = 1'b0; cyc(HALF - 1);
         end else begin
            cyc(HALF);
         end
         if (k == nfalls && k < 11) return;
         dev_c = 1'b1;
         if (k <= 10) bits[k] = ps2d_in;
         if (k == 10) begin
            cyc(10); dev_d = ~ack; cyc(HALF - 10);
         end else if (k == 11) begin
            cyc(5); dev_d = 1'b1; cyc(HALF - 5);
         end else if (k == glitch_k) begin
            cyc(15); dev_c = 1'b0; cyc(3); dev_c = 1'b1; cyc(HALF - 18);
         end else begin
            cyc(HALF);
         end
      end
   endtask

   task automatic do_frame(input logic [7:0] b, input bit ack, input int glitch_k, input int poke_k,
                           output logic [10:0] bits, output int inh, output int rts,
                           output int dl, output int de, output int iw);
      int bl, be;
      bl = n_listo;
      be = n_err;
      start_tx(b);
      wait_release(inh, rts);
      dev_frame(ack, 11, glitch_k, poke_k, bits);
      wait_idle(iw);
      cyc(5);
      dl = n_listo - bl;
      de = n_err - be;
   endtask

   task automatic test_reset();
      rst = 1'b1; iniciar = 1'b1; dato = 8'hAA;
      cyc(3);
      tests++; if (ps2c_oe !== 1'b0) begin fails++; $display("FAIL reset_ps2c_oe: got %b expected 0", ps2c_oe); end
      tests++; if (ps2d_oe !== 1'b0) begin fails++; $display("FAIL reset_ps2d_oe: got %b expected 0", ps2d_oe); end
      tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
      tests++; if (listo !== 1'b0) begin fails++; $display("FAIL reset_listo: got %b expected 0", listo); end
      tests++; if (error_tx !== 1'b0) begin fails++; $display("FAIL reset_error_tx: got %b expected 0", error_tx); end
      iniciar = 1'b0; rst = 1'b0;
      cyc(2);
      tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got %b expected 0", ocupado); end
   endtask

   task automatic test_send_ed();
      logic [10:0] bits; int inh, rts, dl, de, iw;
      do_frame(8'hED, 1'b1, 0, 0, bits, inh, rts, dl, de, iw);
      tests++; if (inh != INH) begin fails++; $display("FAIL ed_inhibit_len: got %0d expected %0d", inh, INH); end
      tests++; if (rts != RTSC) begin fails++; $display("FAIL ed_rts_len: got %0d expected %0d", rts, RTSC); end
      tests++; if (bits !== 11'h7DA) begin fails++; $display("FAIL ed_wire: got %03h expected 7da", bits); end
      tests++; if (dl != 1) begin fails++; $display("FAIL ed_listo: got %0d pulses expected 1", dl); end
      tests++; if (de != 0) begin fails++; $display("FAIL ed_error: got %0d pulses expected 0", de); end
      tests++; if (iw >= 5000) begin fails++; $display("FAIL ed_idle: ocupado stuck, waited %0d", iw); end
   endtask

   task automatic test_parity();
      logic [10:0] bits; int inh, rts, dl, de, iw;
      do_frame(8'h07, 1'b1, 0, 0, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h40E) begin fails++; $display("FAIL p07_wire: got %03h expected 40e", bits); end
      tests++; if (bits[9] !== 1'b0) begin fails++; $display("FAIL p07_parity: got %b expected 0", bits[9]); end
      tests++; if (dl != 1) begin fails++; $display("FAIL p07_listo: got %0d expected 1", dl); end
      do_frame(8'h00, 1'b1, 0, 0, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h600) begin fails++; $display("FAIL p00_wire: got %03h expected 600", bits); end
      tests++; if (bits[9] !== 1'b1) begin fails++; $display("FAIL p00_parity: got %b expected 1", bits[9]); end
      tests++; if (dl != 1) begin fails++; $display("FAIL p00_listo: got %0d expected 1", dl); end
   endtask

   task automatic test_nack();
      logic [10:0] bits; int inh, rts, dl, de, iw;
      do_frame(8'h02, 1'b0, 0, 0, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h404) begin fails++; $display("FAIL nack_wire: got %03h expected 404", bits); end
      tests++; if (de != 1) begin fails++; $display("FAIL nack_error: got %0d pulses expected 1", de); end
      tests++; if (dl != 0) begin fails++; $display("FAIL nack_listo: got %0d pulses expected 0", dl); end
      tests++; if (iw >= 5000) begin fails++; $display("FAIL nack_idle: ocupado stuck, waited %0d", iw); end
   endtask

   task automatic test_timeout();
      int inh, rts, k, bl, be;
      bl = n_listo; be = n_err;
      start_tx(8'h3C);
      wait_release(inh, rts);
      k = 1;
      while (!error_tx && k < TMO + 100) begin cyc(1); k++; end
      tests++; if (k != TMO) begin fails++; $display("FAIL tmo_cycles: got %0d expected %0d", k, TMO); end
      cyc(1);
      tests++; if (ps2c_oe !== 1'b0) begin fails++; $display("FAIL tmo_ps2c_oe: got %b expected 0", ps2c_oe); end
      tests++; if (ps2d_oe !== 1'b0) begin fails++; $display("FAIL tmo_ps2d_oe: got %b expected 0", ps2d_oe); end
      tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL tmo_ocupado: got %b expected 0", ocupado); end
      cyc(2);
      tests++; if (n_err - be != 1) begin fails++; $display("FAIL tmo_error: got %0d pulses expected 1", n_err - be); end
      tests++; if (n_listo - bl != 0) begin fails++; $display("FAIL tmo_listo: got %0d pulses expected 0", n_listo - bl); end
   endtask

   task automatic test_busy_drop();
      logic [10:0] bits; int inh, rts, dl, de, iw, seen;
      do_frame(8'h55, 1'b1, 0, 3, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h6AA) begin fails++; $display("FAIL busy_wire: got %03h expected 6aa", bits); end
      tests++; if (dl != 1) begin fails++; $display("FAIL busy_listo: got %0d expected 1", dl); end
      seen = 0;
      repeat (200) begin if (ocupado) seen++; cyc(1); end
      tests++; if (seen != 0) begin fails++; $display("FAIL busy_dropped: ocupado high %0d cycles expected 0", seen); end
   endtask

   task automatic test_reset_mid();
      logic [10:0] bits; int inh, rts, dl, de, iw, bl, be;
      bl = n_listo; be = n_err;
      start_tx(8'hE5);
      wait_release(inh, rts);
      dev_frame(1'b1, 5, 0, 0, bits);
      tests++; if (ps2d_oe !== 1'b1) begin fails++; $display("FAIL mid_bit4_drive: got %b expected 1", ps2d_oe); end
      rst = 1'b1;
      cyc(1);
      tests++; if (ps2c_oe !== 1'b0) begin fails++; $display("FAIL mid_rst_ps2c_oe: got %b expected 0", ps2c_oe); end
      tests++; if (ps2d_oe !== 1'b0) begin fails++; $display("FAIL mid_rst_ps2d_oe: got %b expected 0", ps2d_oe); end
      tests++; if (ocupado !== 1'b0) begin fails++; $display("FAIL mid_rst_ocupado: got %b expected 0", ocupado); end
      rst = 1'b0;
      dev_c = 1'b1;
      cyc(30);
      tests++; if (n_listo != bl || n_err != be) begin fails++; $display("FAIL mid_rst_pulses: got listo %0d error %0d expected 0 0", n_listo - bl, n_err - be); end
      do_frame(8'hF4, 1'b1, 0, 0, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h5E8) begin fails++; $display("FAIL f4_wire: got %03h expected 5e8", bits); end
      tests++; if (dl != 1 || de != 0) begin fails++; $display("FAIL f4_done: got listo %0d error %0d expected 1 0", dl, de); end
   endtask

   task automatic test_glitch();
      logic [10:0] bits; int inh, rts, dl, de, iw;
      do_frame(8'hA3, 1'b1, 4, 0, bits, inh, rts, dl, de, iw);
      tests++; if (bits !== 11'h746) begin fails++; $display("FAIL glitch_wire: got %03h expected 746", bits); end
      tests++; if (dl != 1) begin fails++; $display("FAIL glitch_listo: got %0d expected 1", dl); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_parity();
      test_nack();
      test_timeout();
      test_busy_drop();
      test_reset_mid();
      test_glitch();
      tests++; if (n_both != 0) begin fails++; $display("FAIL listo_error_overlap: got %0d cycles expected 0", n_both); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
